// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32 x 64-bit register file with two combinational read
// ports (BusA/BusB, feeding the ALU operands) and one clocked write port
// (BusW writeback). Entry ZERO_REG reads as zero and has no storage.
//
// Build option: define REGFILE_BYPASS_EN to forward BusW onto a read port
// in the same cycle as a write to the index it is reading. Without the
// macro, a read during a write returns the stored (old) value. The timing
// of the storage update is the same in both builds.
module reg_file_2r1w #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW,
  input  logic              RegWr,
  input  logic [DATA_W-1:0] BusW,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  // Current contents of every entry, as seen by the read muxes.
  logic [DATA_W-1:0] rd_vals [NUM_REGS];

  // A write is accepted only outside reset and never to the zero register.
  logic wr_en;
  assign wr_en = RegWr && !Reset && (RW != ZERO_IDX);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_ent
    if (i == ZERO_REG) begin : g_zero
      // Hardwired zero: no flop is built for this index.
      assign rd_vals[i] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] ent_d;
      logic [DATA_W-1:0] ent_q;

      // Next value: take BusW when this entry is the write target.
      always_comb begin
        ent_d = ent_q;
        if (wr_en && (RW == ADDR_W'(i))) begin
          ent_d = BusW;
        end
      end

      // Entry storage; reset clears it immediately, independent of Clk.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          ent_q <= '0;
        end else begin
          ent_q <= ent_d;
        end
      end

      assign rd_vals[i] = ent_q;
    end
  end

  // Read port A: stored value, optionally overridden by a same-cycle write.
  always_comb begin
    BusA = rd_vals[RA];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (RW == RA)) begin
      BusA = BusW;
    end
`endif
    if (Reset || (RA == ZERO_IDX)) begin
      BusA = '0;
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    BusB = rd_vals[RB];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (RW == RB)) begin
      BusB = BusW;
    end
`endif
    if (Reset || (RB == ZERO_IDX)) begin
      BusB = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed scenarios followed by
// randomized traffic, compared against an array-based reference model.
module tb_reg_file_2r1w;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;
  localparam int ZREG   = 31;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [ADDR_W-1:0] RA, RB, RW;
  logic              RegWr;
  logic [DATA_W-1:0] BusW;
  logic [DATA_W-1:0] BusA, BusB;

  reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZREG)) dut (
    .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .RW(RW),
    .RegWr(RegWr), .BusW(BusW), .BusA(BusA), .BusB(BusB)
  );

  always #5 Clk = ~Clk;

  logic [DATA_W-1:0] model [NREGS];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_rd(input int addr);
    if (Reset) return '0;
    if (addr == ZREG) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWr && (int'(RW) == addr) && (int'(RW) != ZREG)) return BusW;
`endif
    return model[addr];
  endfunction

  // One clock edge; the model follows the architectural write rule.
  task automatic cycle();
    bit do_w;
    int wa;
    logic [DATA_W-1:0] wd;
    do_w = RegWr && !Reset && (int'(RW) != ZREG);
    wa = int'(RW);
    wd = BusW;
    @(posedge Clk);
    #1;
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) model[i] = '0;
    end else if (do_w) begin
      model[wa] = wd;
    end
  endtask

  task automatic write_reg(input int idx, input logic [DATA_W-1:0] val);
    RegWr = 1'b1; RW = ADDR_W'(idx); BusW = val;
    cycle();
    RegWr = 1'b0;
  endtask

  task automatic read_a(input string tag, input int idx);
    RA = ADDR_W'(idx);
    #1;
    check(tag, BusA, exp_rd(idx));
  endtask

  initial begin
    logic [DATA_W-1:0] snap [NREGS];
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    Reset = 1'b1; RegWr = 1'b0; RA = '0; RB = '0; RW = '0; BusW = '0;

    // Reset state
    RA = 5'd3; RB = 5'd7;
    #2;
    check("reset_busa", BusA, 64'h0);
    check("reset_busb", BusB, 64'h0);
    @(negedge Clk);
    Reset = 1'b0;
    cycle();

    // Write/read X3 on both ports
    write_reg(3, 64'h7F0C4B3F);
    RA = 5'd3; RB = 5'd3;
    #1;
    check("wr3_busa", BusA, 64'h7F0C4B3F);
    check("wr3_busb", BusB, 64'h7F0C4B3F);

    // Zero register ignores writes; nothing else changes
    for (int i = 0; i < NREGS; i++) snap[i] = model[i];
    write_reg(31, 64'hFFFFFFFFFFFFFFFF);
    read_a("zero_reg", 31);
    check("zero_reg_abs", BusA, 64'h0);
    for (int i = 0; i < NREGS - 1; i++) begin
      RA = ADDR_W'(i);
      #1;
      check($sformatf("zero_wr_x%0d", i), BusA, snap[i]);
    end

    // Dual port and ALU sum
    write_reg(1, 64'h82C639269A);
    write_reg(2, 64'h152672E37E);
    RA = 5'd1; RB = 5'd2;
    #1;
    check("dual_busa", BusA, 64'h82C639269A);
    check("dual_busb", BusB, 64'h152672E37E);
    check("dual_add", BusA + BusB, 64'h97ECAC0A18);

    // Read during write
    write_reg(4, 64'h1234);
    RegWr = 1'b1; RW = 5'd4; RA = 5'd4; BusW = 64'hABCD0000;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_before", BusA, 64'hABCD0000);
`else
    check("rdw_before", BusA, 64'h1234);
`endif
    cycle();
    RegWr = 1'b0;
    #1;
    check("rdw_after", BusA, 64'hABCD0000);

    // Disabled write over three edges
    write_reg(6, 64'h1111_2222_3333_4444);
    RegWr = 1'b0; RW = 5'd6; BusW = 64'h5A0E7A39;
    repeat (3) cycle();
    read_a("nowr_x6", 6);
    check("nowr_x6_abs", BusA, 64'h1111_2222_3333_4444);

    // Mid-cycle reset pulse clears storage at once
    write_reg(5, 64'hFA49D367EB2);
    read_a("pre_rst_x5", 5);
    check("pre_rst_x5_abs", BusA, 64'hFA49D367EB2);
    #2 Reset = 1'b1;
    #1;
    check("midrst_busa", BusA, 64'h0);
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    #1 Reset = 1'b0;
    #1;
    check("postrst_x5", BusA, 64'h0);
    read_a("postrst_x3", 3);

    // Write on an edge with Reset high is dropped; first write after release lands
    @(negedge Clk);
    Reset = 1'b1; RegWr = 1'b1; RW = 5'd7; BusW = 64'hDEAD_BEEF_0000_0007;
    cycle();
    Reset = 1'b0; RegWr = 1'b0;
    read_a("rst_edge_drop", 7);
    check("rst_edge_drop_abs", BusA, 64'h0);
    write_reg(7, 64'hCAFE_0000_0000_0007);
    read_a("first_wr_after_rst", 7);
    check("first_wr_abs", BusA, 64'hCAFE_0000_0000_0007);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      RegWr = ($urandom_range(0, 3) != 0);
      RW    = ADDR_W'($urandom_range(0, NREGS - 1));
      BusW  = {$urandom, $urandom};
      RA    = ($urandom_range(0, 3) == 0) ? RW : ADDR_W'($urandom_range(0, NREGS - 1));
      RB    = ($urandom_range(0, 7) == 0) ? 5'd31 : ADDR_W'($urandom_range(0, NREGS - 1));
      #1;
      check("rand_busa", BusA, exp_rd(int'(RA)));
      check("rand_busb", BusB, exp_rd(int'(RB)));
      cycle();
    end

    // Final sweep of every entry
    RegWr = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      RA = ADDR_W'(i); RB = ADDR_W'(NREGS - 1 - i);
      #1;
      check("sweep_a", BusA, exp_rd(i));
      check("sweep_b", BusB, exp_rd(NREGS - 1 - i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
